// File: rtl/axi_rd_arbiter.sv
// Arbitrates instruction- and data-side refill reads onto one AXI AR/R channel pair,
// tagging each burst with {port, sequence} and routing R beats back by the ID's port bit.
module axi_rd_arbiter #(
    parameter int ADDR_W           = 32,
    parameter int ID_W             = 4,
    parameter int MAX_OUT          = 4,
    parameter int LINE_BYTE_OFFSET = 6,
    parameter int PRIO_DATA        = 0,
    localparam int CNT_W           = $clog2(MAX_OUT + 1)
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_ireq_valid,
    input  logic [ADDR_W-1:0] i_ireq_addr,
    input  logic [7:0]        i_ireq_len,
    input  logic [2:0]        i_ireq_size,
    output logic              o_ireq_ready,
    input  logic              i_dreq_valid,
    input  logic [ADDR_W-1:0] i_dreq_addr,
    input  logic [7:0]        i_dreq_len,
    input  logic [2:0]        i_dreq_size,
    output logic              o_dreq_ready,
    input  logic              i_wr_busy,
    input  logic [ADDR_W-1:0] i_wr_addr,
    output logic              o_axi_arvalid,
    output logic [ADDR_W-1:0] o_axi_araddr,
    output logic [7:0]        o_axi_arlen,
    output logic [2:0]        o_axi_arsize,
    output logic [1:0]        o_axi_arburst,
    output logic [ID_W-1:0]   o_axi_arid,
    input  logic              i_axi_arready,
    input  logic              i_axi_rvalid,
    input  logic [ID_W-1:0]   i_axi_rid,
    input  logic [31:0]       i_axi_rdata,
    input  logic [1:0]        i_axi_rresp,
    input  logic              i_axi_rlast,
    output logic              o_axi_rready,
    output logic              o_ir_valid,
    output logic              o_dr_valid,
    output logic              o_r_last,
    output logic [31:0]       o_r_data,
    output logic [1:0]        o_r_resp,
    output logic [CNT_W-1:0]  o_iout_cnt,
    output logic [CNT_W-1:0]  o_dout_cnt,
    output logic              o_err,
    output logic              o_idle
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [ID_W-2:0]  SEQ_ONE = (ID_W-1)'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ADDR_W-1:0]  r_araddr;
    logic [7:0]         r_arlen;
    logic [2:0]         r_arsize;
    logic [ID_W-1:0]    r_arid;
    logic [ID_W-2:0]    r_iseq;
    logic [ID_W-2:0]    r_dseq;
    logic [CNT_W-1:0]   r_icnt;
    logic [CNT_W-1:0]   r_dcnt;
    logic               r_last_grant_d;
    logic               r_err;

    logic               w_ihaz;
    logic               w_dhaz;
    logic               w_ielig;
    logic               w_delig;
    logic               w_igrant;
    logic               w_dgrant;
    logic               w_idone;
    logic               w_ddone;
    logic               w_unused_bits;

    assign w_ihaz  = i_wr_busy &&
                     (i_wr_addr[ADDR_W-1:LINE_BYTE_OFFSET] == i_ireq_addr[ADDR_W-1:LINE_BYTE_OFFSET]);
    assign w_dhaz  = i_wr_busy &&
                     (i_wr_addr[ADDR_W-1:LINE_BYTE_OFFSET] == i_dreq_addr[ADDR_W-1:LINE_BYTE_OFFSET]);
    assign w_ielig = i_ireq_valid && (r_icnt < CNT_MAX) && !w_ihaz;
    assign w_delig = i_dreq_valid && (r_dcnt < CNT_MAX) && !w_dhaz;

    always_comb begin
        w_state_nxt = r_state;
        w_igrant    = 1'b0;
        w_dgrant    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (PRIO_DATA != 0) begin
                    if (w_delig)      w_dgrant = 1'b1;
                    else if (w_ielig) w_igrant = 1'b1;
                end else if (w_ielig && w_delig) begin
                    // Tie goes to whichever port did not win last time.
                    w_igrant = r_last_grant_d;
                    w_dgrant = !r_last_grant_d;
                end else begin
                    w_igrant = w_ielig;
                    w_dgrant = w_delig;
                end
                if (w_igrant || w_dgrant) w_state_nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                if (i_axi_arready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state        <= ST_IDLE;
            r_araddr       <= '0;
            r_arlen        <= '0;
            r_arsize       <= '0;
            r_arid         <= '0;
            r_iseq         <= '0;
            r_dseq         <= '0;
            r_last_grant_d <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            if (w_igrant) begin
                r_araddr       <= i_ireq_addr;
                r_arlen        <= i_ireq_len;
                r_arsize       <= i_ireq_size;
                r_arid         <= {1'b0, r_iseq};
                r_iseq         <= r_iseq + SEQ_ONE;
                r_last_grant_d <= 1'b0;
            end else if (w_dgrant) begin
                r_araddr       <= i_dreq_addr;
                r_arlen        <= i_dreq_len;
                r_arsize       <= i_dreq_size;
                r_arid         <= {1'b1, r_dseq};
                r_dseq         <= r_dseq + SEQ_ONE;
                r_last_grant_d <= 1'b1;
            end
        end
    end

    assign w_idone = i_axi_rvalid && i_axi_rlast && !i_axi_rid[ID_W-1];
    assign w_ddone = i_axi_rvalid && i_axi_rlast &&  i_axi_rid[ID_W-1];

    // A completion with nothing outstanding is flagged and the count saturates at zero.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_icnt <= '0;
            r_dcnt <= '0;
            r_err  <= 1'b0;
        end else begin
            case ({w_igrant, w_idone})
                2'b10:   r_icnt <= r_icnt + CNT_ONE;
                2'b01:   if (r_icnt != '0) r_icnt <= r_icnt - CNT_ONE;
                default: r_icnt <= r_icnt;
            endcase
            case ({w_dgrant, w_ddone})
                2'b10:   r_dcnt <= r_dcnt + CNT_ONE;
                2'b01:   if (r_dcnt != '0) r_dcnt <= r_dcnt - CNT_ONE;
                default: r_dcnt <= r_dcnt;
            endcase
            if ((w_idone && r_icnt == '0) || (w_ddone && r_dcnt == '0)) r_err <= 1'b1;
        end
    end

    assign o_ireq_ready  = w_igrant && i_rst_n;
    assign o_dreq_ready  = w_dgrant && i_rst_n;
    assign o_axi_arvalid = (r_state == ST_ISSUE);
    assign o_axi_araddr  = r_araddr;
    assign o_axi_arlen   = r_arlen;
    assign o_axi_arsize  = r_arsize;
    assign o_axi_arburst = (r_arlen == 8'd0) ? 2'b00 : 2'b01;
    assign o_axi_arid    = r_arid;
    assign o_axi_rready  = 1'b1;
    assign o_ir_valid    = i_axi_rvalid && !i_axi_rid[ID_W-1];
    assign o_dr_valid    = i_axi_rvalid &&  i_axi_rid[ID_W-1];
    assign o_r_last      = i_axi_rlast;
    assign o_r_data      = i_axi_rdata;
    assign o_r_resp      = i_axi_rresp;
    assign o_iout_cnt    = r_icnt;
    assign o_dout_cnt    = r_dcnt;
    assign o_err         = r_err;
    assign o_idle        = (r_state == ST_IDLE) && (r_icnt == '0) && (r_dcnt == '0);

    assign w_unused_bits = ^{i_axi_rid[ID_W-2:0], i_wr_addr[LINE_BYTE_OFFSET-1:0]};

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: a round-robin instance carries most scenarios,
// a second instance built with fixed data priority checks the priority mode.
module tb_axi_rd_arbiter;

    localparam int ADDR_W = 32;
    localparam int ID_W   = 4;
    localparam int CNT_W  = 3;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              ivalid, dvalid;
    logic [ADDR_W-1:0] iaddr, daddr;
    logic [7:0]        ilen, dlen;
    logic [2:0]        isize, dsize;
    logic              iready, dready;
    logic              wr_busy;
    logic [ADDR_W-1:0] wr_addr;
    logic              arvalid;
    logic [ADDR_W-1:0] araddr;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic [ID_W-1:0]   arid;
    logic              arready;
    logic              rvalid;
    logic [ID_W-1:0]   rid;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rready;
    logic              ir_valid, dr_valid, r_last;
    logic [31:0]       r_data;
    logic [1:0]        r_resp;
    logic [CNT_W-1:0]  icnt, dcnt;
    logic              err, idle;

    logic              p_ivalid, p_dvalid, p_arready;
    logic              p_iready, p_dready, p_arvalid;
    logic [ADDR_W-1:0] p_araddr;
    logic [7:0]        p_arlen;
    logic [2:0]        p_arsize;
    logic [1:0]        p_arburst;
    logic [ID_W-1:0]   p_arid;
    logic              p_rready, p_ir_valid, p_dr_valid, p_r_last;
    logic [31:0]       p_r_data;
    logic [1:0]        p_r_resp;
    logic [CNT_W-1:0]  p_icnt, p_dcnt;
    logic              p_err, p_idle;
    logic              p_rvalid;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    axi_rd_arbiter #(.PRIO_DATA(0)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ireq_valid(ivalid), .i_ireq_addr(iaddr), .i_ireq_len(ilen), .i_ireq_size(isize),
        .o_ireq_ready(iready),
        .i_dreq_valid(dvalid), .i_dreq_addr(daddr), .i_dreq_len(dlen), .i_dreq_size(dsize),
        .o_dreq_ready(dready),
        .i_wr_busy(wr_busy), .i_wr_addr(wr_addr),
        .o_axi_arvalid(arvalid), .o_axi_araddr(araddr), .o_axi_arlen(arlen),
        .o_axi_arsize(arsize), .o_axi_arburst(arburst), .o_axi_arid(arid),
        .i_axi_arready(arready),
        .i_axi_rvalid(rvalid), .i_axi_rid(rid), .i_axi_rdata(rdata), .i_axi_rresp(rresp),
        .i_axi_rlast(rlast), .o_axi_rready(rready),
        .o_ir_valid(ir_valid), .o_dr_valid(dr_valid), .o_r_last(r_last),
        .o_r_data(r_data), .o_r_resp(r_resp),
        .o_iout_cnt(icnt), .o_dout_cnt(dcnt), .o_err(err), .o_idle(idle)
    );

    axi_rd_arbiter #(.PRIO_DATA(1)) u_dut_prio (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_ireq_valid(p_ivalid), .i_ireq_addr(32'h0000_1000), .i_ireq_len(8'd3), .i_ireq_size(3'd2),
        .o_ireq_ready(p_iready),
        .i_dreq_valid(p_dvalid), .i_dreq_addr(32'h0000_2000), .i_dreq_len(8'd3), .i_dreq_size(3'd2),
        .o_dreq_ready(p_dready),
        .i_wr_busy(1'b0), .i_wr_addr(32'h0),
        .o_axi_arvalid(p_arvalid), .o_axi_araddr(p_araddr), .o_axi_arlen(p_arlen),
        .o_axi_arsize(p_arsize), .o_axi_arburst(p_arburst), .o_axi_arid(p_arid),
        .i_axi_arready(p_arready),
        .i_axi_rvalid(p_rvalid), .i_axi_rid(4'h0), .i_axi_rdata(32'h0), .i_axi_rresp(2'b00),
        .i_axi_rlast(1'b0), .o_axi_rready(p_rready),
        .o_ir_valid(p_ir_valid), .o_dr_valid(p_dr_valid), .o_r_last(p_r_last),
        .o_r_data(p_r_data), .o_r_resp(p_r_resp),
        .o_iout_cnt(p_icnt), .o_dout_cnt(p_dcnt), .o_err(p_err), .o_idle(p_idle)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        ivalid = 0; dvalid = 0; iaddr = '0; daddr = '0; ilen = '0; dlen = '0;
        isize = '0; dsize = '0; wr_busy = 0; wr_addr = '0; arready = 0;
        rvalid = 0; rid = '0; rdata = '0; rresp = '0; rlast = 0;
        p_ivalid = 0; p_dvalid = 0; p_arready = 0;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_inputs();
        @(negedge clk);
        rst_n = 1;
        step();
    endtask

    initial begin
        p_rvalid = 0;
        rst_n = 0;
        clear_inputs();
        #2;
        chk("rst_iready", 32'(iready), 0);
        chk("rst_arvalid", 32'(arvalid), 0);
        chk("rst_idle", 32'(idle), 1);
        chk("rst_err", 32'(err), 0);
        chk("rst_icnt", 32'(icnt), 0);
        chk("rst_dcnt", 32'(dcnt), 0);
        chk("rst_rready", 32'(rready), 1);

        // single instruction burst
        do_reset();
        ivalid = 1; iaddr = 32'h1fc0_0000; ilen = 8'd7; isize = 3'd2;
        #1;
        chk("t1_iready", 32'(iready), 1);
        chk("t1_dready", 32'(dready), 0);
        step();
        ivalid = 0;
        chk("t1_arvalid", 32'(arvalid), 1);
        chk("t1_araddr", araddr, 32'h1fc0_0000);
        chk("t1_arlen", 32'(arlen), 7);
        chk("t1_arsize", 32'(arsize), 2);
        chk("t1_arburst", 32'(arburst), 1);
        chk("t1_arid", 32'(arid), 0);
        chk("t1_icnt", 32'(icnt), 1);
        chk("t1_idle_busy", 32'(idle), 0);
        arready = 1;
        step();
        arready = 0;
        chk("t1_arvalid_drop", 32'(arvalid), 0);
        for (int i = 0; i < 8; i++) begin
            rvalid = 1; rid = 4'h0; rdata = 32'hA000_0000 + 32'(i); rlast = (i == 7);
            #1;
            chk("t1_ir_valid", 32'(ir_valid), 1);
            chk("t1_dr_valid", 32'(dr_valid), 0);
            chk("t1_r_data", r_data, 32'hA000_0000 + 32'(i));
            chk("t1_r_last", 32'(r_last), (i == 7) ? 1 : 0);
            step();
        end
        rvalid = 0; rlast = 0;
        chk("t1_icnt_done", 32'(icnt), 0);
        chk("t1_idle_done", 32'(idle), 1);

        // round-robin alternation with both ports always requesting
        do_reset();
        ivalid = 1; iaddr = 32'h0000_1000; ilen = 8'd3; isize = 3'd2;
        dvalid = 1; daddr = 32'h0000_2000; dlen = 8'd0; dsize = 3'd2;
        arready = 1;
        begin
            logic [3:0] exp_id [4];
            exp_id[0] = 4'h0; exp_id[1] = 4'h8; exp_id[2] = 4'h1; exp_id[3] = 4'h9;
            for (int k = 0; k < 4; k++) begin
                #1;
                chk("rr_iready", 32'(iready), (k % 2 == 0) ? 1 : 0);
                chk("rr_dready", 32'(dready), (k % 2 == 1) ? 1 : 0);
                step();
                chk("rr_arvalid", 32'(arvalid), 1);
                chk("rr_arid", 32'(arid), 32'(exp_id[k]));
                chk("rr_no_ready_issue", 32'({iready, dready}), 0);
                step();
            end
        end
        chk("rr_burst_single", 32'(arburst), 0);
        ivalid = 0; dvalid = 0;
        chk("rr_icnt", 32'(icnt), 2);
        chk("rr_dcnt", 32'(dcnt), 2);

        // fixed data priority instance, data wins until it is full
        p_ivalid = 1; p_dvalid = 1; p_arready = 1;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("pd_dready", 32'(p_dready), 1);
            chk("pd_iready", 32'(p_iready), 0);
            step();
            chk("pd_arid", 32'(p_arid), 32'(8 + k));
            step();
        end
        chk("pd_dcnt_full", 32'(p_dcnt), 4);
        #1;
        chk("pd_iready_after_full", 32'(p_iready), 1);
        chk("pd_dready_full", 32'(p_dready), 0);
        step();
        chk("pd_arid_instr", 32'(p_arid), 0);
        p_ivalid = 0; p_dvalid = 0;
        step();

        // outstanding limit on the instruction port
        do_reset();
        arready = 1;
        ivalid = 1; iaddr = 32'h0000_3000; ilen = 8'd3; isize = 3'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            chk("lim_iready", 32'(iready), 1);
            step();
            step();
        end
        chk("lim_icnt_full", 32'(icnt), 4);
        #1;
        chk("lim_blocked", 32'(iready), 0);
        step();
        chk("lim_blocked2", 32'(iready), 0);
        rvalid = 1; rlast = 1; rid = 4'h0;
        #1;
        chk("lim_blocked_on_done", 32'(iready), 0);
        step();
        rvalid = 0; rlast = 0;
        #1;
        chk("lim_icnt_after_done", 32'(icnt), 3);
        chk("lim_ready_again", 32'(iready), 1);
        step();
        ivalid = 0;
        chk("lim_arid_seq4", 32'(arid), 4);
        step();

        // write-back hazard hold-off
        do_reset();
        arready = 1;
        wr_busy = 1; wr_addr = 32'h8000_1040;
        dvalid = 1; daddr = 32'h8000_1060; dlen = 8'd7; dsize = 3'd2;
        ivalid = 1; iaddr = 32'h8000_2000; ilen = 8'd7; isize = 3'd2;
        #1;
        chk("haz_dready_held", 32'(dready), 0);
        chk("haz_iready", 32'(iready), 1);
        step();
        ivalid = 0;
        chk("haz_i_arid", 32'(arid), 0);
        chk("haz_i_araddr", araddr, 32'h8000_2000);
        step();
        #1;
        chk("haz_dready_still", 32'(dready), 0);
        wr_busy = 0;
        #1;
        chk("haz_dready_clear", 32'(dready), 1);
        step();
        dvalid = 0;
        chk("haz_d_arid", 32'(arid), 8);
        chk("haz_d_araddr", araddr, 32'h8000_1060);
        step();
        wr_busy = 1; wr_addr = 32'h8000_1040;
        dvalid = 1; daddr = 32'h8000_1000;
        #1;
        chk("haz_other_line", 32'(dready), 1);
        step();
        dvalid = 0; wr_busy = 0;
        step();

        // AR stall, then reset while issuing
        do_reset();
        arready = 0;
        ivalid = 1; iaddr = 32'h0040_0080; ilen = 8'd3; isize = 3'd2;
        dvalid = 1; daddr = 32'h0050_0000; dlen = 8'd3; dsize = 3'd2;
        #1;
        chk("st_iready", 32'(iready), 1);
        step();
        for (int k = 0; k < 10; k++) begin
            chk("st_arvalid", 32'(arvalid), 1);
            chk("st_araddr", araddr, 32'h0040_0080);
            chk("st_arid", 32'(arid), 0);
            chk("st_arlen", 32'(arlen), 3);
            chk("st_no_ready", 32'({iready, dready}), 0);
            step();
        end
        #3;
        rst_n = 0;
        #1;
        chk("st_rst_arvalid", 32'(arvalid), 0);
        chk("st_rst_icnt", 32'(icnt), 0);
        chk("st_rst_iready", 32'(iready), 0);
        ivalid = 0; dvalid = 0;
        @(negedge clk);
        rst_n = 1;
        step();

        // spurious completion and simultaneous grant/completion
        rvalid = 1; rlast = 1; rid = 4'h8; rdata = 32'h55;
        #1;
        chk("err_dr_valid", 32'(dr_valid), 1);
        chk("err_ir_valid", 32'(ir_valid), 0);
        chk("err_before", 32'(err), 0);
        step();
        rvalid = 0; rlast = 0;
        chk("err_set", 32'(err), 1);
        chk("err_dcnt", 32'(dcnt), 0);
        step();
        chk("err_sticky", 32'(err), 1);
        arready = 1;
        ivalid = 1; iaddr = 32'h0000_0100; ilen = 8'd1; isize = 3'd2;
        step();
        ivalid = 0;
        step();
        chk("same_icnt_pre", 32'(icnt), 1);
        ivalid = 1; rvalid = 1; rlast = 1; rid = 4'h0;
        #1;
        chk("same_iready", 32'(iready), 1);
        step();
        ivalid = 0; rvalid = 0; rlast = 0;
        chk("same_icnt", 32'(icnt), 1);
        chk("same_err_sticky", 32'(err), 1);
        step();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
